// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/mem/exec sequencer for the 16-bit accumulator CPU.
// Optional feature: define CPU_SEQ_HALT_EN to make an all-ones instruction halt the core.
module cpu_sequencer #(
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned MEMORY_ADDR_WIDTH = 10,
  parameter logic [MEMORY_ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  output logic                         imem_req,
  output logic [MEMORY_ADDR_WIDTH-1:0] imem_addr,
  input  logic                         imem_ack,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  input  logic                         dec_RF_we,
  input  logic                         dec_MEM_we,
  input  logic                         dec_A_we,
  input  logic                         dmem_access,
  output logic                         dmem_req,
  input  logic                         dmem_ack,
  output logic                         RF_we,
  output logic                         MEM_we,
  output logic                         A_we,
  input  logic                         pc_load,
  input  logic [MEMORY_ADDR_WIDTH-1:0] pc_target,
  output logic [MEMORY_ADDR_WIDTH-1:0] pc,
  output logic                         busy,
  output logic                         halted,
  output logic                         fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t                         state;
  state_t                         state_next;
  logic [CNT_W-1:0]               wait_cnt;
  logic [CNT_W-1:0]               wait_cnt_next;
  logic [MEMORY_ADDR_WIDTH-1:0]   pc_next;
  logic [INSTRUCTION_WIDTH-1:0]   ir_next;
  logic                           wait_expired;

  assign imem_addr    = pc;
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state, wait counter, PC and IR update
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    pc_next       = pc;
    ir_next       = instruction;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_next    = S_FETCH;
          wait_cnt_next = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_next    = imem_rdata;
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_FAULT;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end
      S_DECODE: begin
`ifdef CPU_SEQ_HALT_EN
        if (instruction == {INSTRUCTION_WIDTH{1'b1}}) begin
          state_next = S_HALT;
        end else
`endif
        if (dmem_access) begin
          state_next    = S_MEM;
          wait_cnt_next = '0;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_next = S_EXEC;
        end else if (wait_expired) begin
          state_next = S_FAULT;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end
      S_EXEC: begin
        pc_next = pc_load ? pc_target : pc + MEMORY_ADDR_WIDTH'(1);
        if (run) begin
          state_next    = S_FETCH;
          wait_cnt_next = '0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  // State register; outputs are registered from the next state so they never see inputs combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      pc          <= RESET_PC;
      instruction <= '0;
      imem_req    <= 1'b0;
      dmem_req    <= 1'b0;
      RF_we       <= 1'b0;
      MEM_we      <= 1'b0;
      A_we        <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      pc          <= pc_next;
      instruction <= ir_next;
      imem_req    <= (state_next == S_FETCH);
      dmem_req    <= (state_next == S_MEM);
      RF_we       <= (state_next == S_EXEC) && dec_RF_we;
      MEM_we      <= (state_next == S_EXEC) && dec_MEM_we;
      A_we        <= (state_next == S_EXEC) && dec_A_we;
      busy        <= (state_next inside {S_FETCH, S_DECODE, S_MEM, S_EXEC});
      fault       <= (state_next == S_FAULT);
    end
  end

`ifdef CPU_SEQ_HALT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else begin
      halted <= (state_next == S_HALT);
    end
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed corner steps plus randomized instruction stream.
// Honors CPU_SEQ_HALT_EN to pick the expected behaviour for the all-ones word.
module tb_cpu_sequencer;

`ifdef CPU_SEQ_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam int unsigned AW = 10;
  localparam int unsigned IW = 16;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] instruction;
  logic          dec_RF_we, dec_MEM_we, dec_A_we;
  logic          dmem_access;
  logic          dmem_req;
  logic          dmem_ack;
  logic          RF_we, MEM_we, A_we;
  logic          pc_load;
  logic [AW-1:0] pc_target;
  logic [AW-1:0] pc;
  logic          busy, halted, fault;

  int            n_checks = 0;
  int            n_fails  = 0;
  logic [AW-1:0] model_pc;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .INSTRUCTION_WIDTH(IW),
    .MEMORY_ADDR_WIDTH(AW),
    .RESET_PC         ('0),
    .TIMEOUT_CYCLES   (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .dec_RF_we  (dec_RF_we),
    .dec_MEM_we (dec_MEM_we),
    .dec_A_we   (dec_A_we),
    .dmem_access(dmem_access),
    .dmem_req   (dmem_req),
    .dmem_ack   (dmem_ack),
    .RF_we      (RF_we),
    .MEM_we     (MEM_we),
    .A_we       (A_we),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] strobes();
    return 32'({RF_we, MEM_we, A_we});
  endfunction

  // Leave IDLE: run sampled high for one edge
  task automatic start();
    run = 1'b1;
    step();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, 32'({imem_req, dmem_req}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_strobe"}, strobes(), 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'(model_pc));
  endtask

  // One full instruction, entered at the first FETCH cycle. The bench plays memory and decoder.
  task automatic run_instr(input logic [IW-1:0] word, input int ilat, input bit dm, input int dlat,
                           input logic [2:0] we, input bit ld, input logic [AW-1:0] tgt,
                           input bit nrun);
    for (int i = 0; i <= ilat; i++) begin
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", 32'(imem_addr), 32'(model_pc));
      chk("fetch_strobe", strobes(), 32'd0);
      chk("fetch_status", 32'({busy, fault, halted, dmem_req}), 32'b1000);
      imem_ack    = (i == ilat);
      imem_rdata  = (i == ilat) ? word : IW'($urandom);
      dmem_ack    = 1'($urandom);
      run         = 1'($urandom);
      pc_load     = 1'($urandom);
      pc_target   = AW'($urandom);
      {dec_RF_we, dec_MEM_we, dec_A_we} = 3'($urandom);
      dmem_access = 1'($urandom);
      step();
    end
    // decode: acks with no request outstanding must be ignored
    imem_ack   = 1'($urandom);
    imem_rdata = IW'($urandom);
    dmem_ack   = 1'($urandom);
    {dec_RF_we, dec_MEM_we, dec_A_we} = we;
    dmem_access = dm;
    chk("dec_ir", 32'(instruction), 32'(word));
    chk("dec_req", 32'({imem_req, dmem_req}), 32'd0);
    chk("dec_strobe", strobes(), 32'd0);
    chk("dec_busy", 32'(busy), 32'd1);
    chk("dec_pc", 32'(pc), 32'(model_pc));
    step();
    if (HALT_EN && word == 16'hFFFF) begin
      chk("halt_flag", 32'(halted), 32'd1);
      chk_idle("halt");
      return;
    end
    if (dm) begin
      for (int j = 0; j <= dlat; j++) begin
        chk("mem_req", 32'({imem_req, dmem_req}), 32'b01);
        chk("mem_strobe", strobes(), 32'd0);
        chk("mem_status", 32'({busy, fault}), 32'b10);
        dmem_ack  = (j == dlat);
        imem_ack  = 1'($urandom);
        run       = 1'($urandom);
        pc_load   = 1'($urandom);
        pc_target = AW'($urandom);
        step();
      end
    end
    chk("exec_strobe", strobes(), 32'(we));
    chk("exec_req", 32'({imem_req, dmem_req}), 32'd0);
    chk("exec_pc", 32'(pc), 32'(model_pc));
    chk("exec_busy", 32'(busy), 32'd1);
    pc_load   = ld;
    pc_target = tgt;
    run       = nrun;
    imem_ack  = 1'($urandom);
    dmem_ack  = 1'($urandom);
    step();
    model_pc = ld ? tgt : model_pc + AW'(1);
    chk("post_pc", 32'(pc), 32'(model_pc));
    chk("post_strobe", strobes(), 32'd0);
    chk("post_req", 32'(imem_req), 32'(nrun));
    chk("post_busy", 32'(busy), 32'(nrun));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    model_pc = '0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    dec_RF_we = 1'b0; dec_MEM_we = 1'b0; dec_A_we = 1'b0;
    dmem_access = 1'b0; dmem_ack = 1'b0; pc_load = 1'b0; pc_target = '0;
    model_pc = '0;
    @(negedge clk);
    step();
    step();
    // Reset state
    chk("rst_ir", 32'(instruction), 32'd0);
    chk("rst_status", 32'({fault, halted}), 32'd0);
    chk_idle("rst");
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_idle("idle_norun");
    end

    // Basic 3-cycle instruction then back-to-back fetch
    start();
    run_instr(16'h0042, 0, 1'b0, 0, 3'b001, 1'b0, '0, 1'b1);
    // Data memory with 3 wait cycles, MEM_we pulse
    run_instr(16'h1234, 0, 1'b1, 3, 3'b010, 1'b0, '0, 1'b1);
    // PC wrap and jump
    run_instr(16'h0100, 0, 1'b0, 0, 3'b100, 1'b1, 10'h3FF, 1'b1);
    run_instr(16'h0200, 1, 1'b0, 0, 3'b000, 1'b0, '0, 1'b1);
    run_instr(16'h0300, 0, 1'b1, 0, 3'b001, 1'b1, 10'h155, 1'b1);
    // Acks in the last allowed wait cycle for both channels
    run_instr(16'h0400, TO - 1, 1'b1, TO - 1, 3'b111, 1'b0, '0, 1'b0);
    chk("limit_fault", 32'(fault), 32'd0);
    for (int k = 0; k < 3; k++) begin
      run = 1'b0;
      step();
      chk_idle("idle_after");
    end
    start();

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      logic [IW-1:0] w;
      int            il, dl;
      bit            nr;
      w  = IW'($urandom_range(0, 16'hFFFE));
      il = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 2));
      dl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(0, 2));
      nr = ($urandom_range(0, 4) != 0);
      run_instr(w, il, 1'($urandom), dl, 3'($urandom), ($urandom_range(0, 3) == 0),
                AW'($urandom), nr);
      if (!nr) begin
        run = 1'b0;
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          step();
          chk_idle("rand_idle");
        end
        start();
      end
    end

    // Reset in the middle of a MEM wait
    imem_ack = 1'b1; imem_rdata = 16'h5555;
    step();
    imem_ack = 1'b0; dmem_access = 1'b1; dmem_ack = 1'b0;
    step();
    chk("rstmem_req1", 32'(dmem_req), 32'd1);
    step();
    chk("rstmem_req2", 32'(dmem_req), 32'd1);
    do_reset();
    chk("rstmem_ir", 32'(instruction), 32'd0);
    chk_idle("rstmem");

    // Fetch timeout: fault after TO wait cycles, sticky regardless of run
    start();
    imem_ack = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      chk("fto_req", 32'({imem_req, fault}), 32'b10);
      dmem_ack = 1'($urandom);
      step();
    end
    chk("fto_fault", 32'(fault), 32'd1);
    for (int k = 0; k < 6; k++) begin
      run      = 1'($urandom);
      imem_ack = 1'($urandom);
      step();
      chk("fto_sticky", 32'(fault), 32'd1);
      chk_idle("fto");
    end

    // Data-memory timeout
    do_reset();
    chk("rst2_fault", 32'(fault), 32'd0);
    start();
    imem_ack = 1'b1; imem_rdata = 16'h0001;
    step();
    imem_ack = 1'b0; dmem_access = 1'b1; dmem_ack = 1'b0;
    step();
    for (int i = 0; i < int'(TO); i++) begin
      chk("mto_req", 32'({dmem_req, fault}), 32'b10);
      imem_ack = 1'($urandom);
      step();
    end
    chk("mto_fault", 32'(fault), 32'd1);
    chk_idle("mto");

    // All-ones word: halts when the feature is built in, otherwise executes normally
    do_reset();
    start();
    run_instr(16'hFFFF, 0, 1'b0, 0, 3'b111, 1'b0, '0, 1'b1);
    if (HALT_EN) begin
      for (int k = 0; k < 4; k++) begin
        run = 1'($urandom);
        step();
        chk("halt_sticky", 32'({halted, fault}), 32'b10);
        chk_idle("halt_after");
      end
    end else begin
      chk("nohalt_flag", 32'(halted), 32'd0);
      chk("nohalt_pc", 32'(pc), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
